// File: rtl/adsr_pulse_overlay.sv
// Beat-triggered ADSR envelope driving a radial brightness overlay on a
// multi-channel pixel stream, behind a 2-stage valid/ready pipeline.
module adsr_pulse_overlay #(
    parameter int CHANNELS     = 3,
    parameter int BITS         = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int RADIUS_W     = 9,
    parameter int TICK_DIV     = 200000,
    parameter int SUS_W        = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS*BITS-1:0]         pix_in,
    input  logic                             valid_in,
    output logic                             module_ready,
    output logic [CHANNELS*BITS-1:0]         pix_out,
    output logic                             valid_out,
    input  logic                             output_ready,
    input  logic [$clog2(IMAGE_WIDTH)-1:0]   pixel_x,
    input  logic [$clog2(IMAGE_HEIGHT)-1:0]  pixel_y,
    input  logic                             filter_enable,
    input  logic                             filter_mode,
    input  logic                             trigger,
    input  logic [BITS-1:0]                  attack_step,
    input  logic [BITS-1:0]                  decay_step,
    input  logic [BITS-1:0]                  release_step,
    input  logic [BITS-1:0]                  sustain_level,
    input  logic [SUS_W-1:0]                 sustain_ticks,
    input  logic [RADIUS_W-1:0]              radius,
    output logic [BITS-1:0]                  env_level,
    output logic [2:0]                       adsr_state
);

    // state   | meaning
    // IDLE    | envelope parked at 0, waiting for a beat
    // ATTACK  | rising by attack_step per tick until ENV_MAX
    // DECAY   | falling by decay_step per tick down to sustain_level
    // SUSTAIN | holding sustain_level for sustain_ticks ticks
    // RELEASE | falling by release_step per tick down to 0
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } adsr_t;

    localparam int PW   = CHANNELS * BITS;
    localparam int XW   = $clog2(IMAGE_WIDTH);
    localparam int YW   = $clog2(IMAGE_HEIGHT);
    localparam int CW   = (XW > YW) ? XW : YW;
    localparam int DW   = 2 * CW + 1;
    localparam int RW2  = 2 * RADIUS_W;
    localparam int CMPW = (DW > RW2) ? DW : RW2;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [BITS-1:0]     ENV_MAX = '1;
    localparam logic signed [XW:0]  CX = (XW+1)'(IMAGE_WIDTH / 2);
    localparam logic signed [YW:0]  CY = (YW+1)'(IMAGE_HEIGHT / 2);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    logic trig_d, trig_pending, trig_rise, trig_go;

    assign trig_rise = trigger & ~trig_d;
    // an edge landing on the tick cycle is consumed by that same tick
    assign trig_go   = trig_pending | trig_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_d       <= 1'b0;
            trig_pending <= 1'b0;
        end else begin
            trig_d <= trigger;
            if (!filter_enable || tick)
                trig_pending <= 1'b0;
            else if (trig_rise)
                trig_pending <= 1'b1;
        end
    end

    adsr_t            state, state_nxt;
    logic [BITS-1:0]  env, env_nxt;
    logic [SUS_W-1:0] sus_cnt, sus_nxt;
    logic [BITS-1:0]  atk, dec, rel;
    logic [BITS:0]    atk_sum;
    logic [BITS-1:0]  env_atk, env_dec, env_rel;
    logic [SUS_W:0]   sus_inc;

    assign atk = (attack_step  == '0) ? BITS'(1) : attack_step;
    assign dec = (decay_step   == '0) ? BITS'(1) : decay_step;
    assign rel = (release_step == '0) ? BITS'(1) : release_step;

    assign atk_sum = {1'b0, env} + {1'b0, atk};
    assign env_atk = atk_sum[BITS] ? ENV_MAX : atk_sum[BITS-1:0];
    assign env_dec = ({1'b0, env} >= ({1'b0, sustain_level} + {1'b0, dec})) ?
                     (env - dec) : sustain_level;
    assign env_rel = (env > rel) ? (env - rel) : '0;
    assign sus_inc = {1'b0, sus_cnt} + (SUS_W+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            env     <= '0;
            sus_cnt <= '0;
        end else begin
            state   <= state_nxt;
            env     <= env_nxt;
            sus_cnt <= sus_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        sus_nxt   = sus_cnt;
        if (!filter_enable) begin
            state_nxt = S_IDLE;
            env_nxt   = '0;
            sus_nxt   = '0;
        end else if (tick) begin
            if (trig_go) begin
                state_nxt = S_ATTACK;
                env_nxt   = env_atk;
            end else begin
                case (state)
                    S_IDLE: env_nxt = '0;
                    S_ATTACK: begin
                        env_nxt = env_atk;
                        if (env_atk == ENV_MAX) state_nxt = S_DECAY;
                    end
                    S_DECAY: begin
                        env_nxt = env_dec;
                        if (env_dec == sustain_level) begin
                            state_nxt = S_SUSTAIN;
                            sus_nxt   = '0;
                        end
                    end
                    S_SUSTAIN: begin
                        sus_nxt = sus_inc[SUS_W-1:0];
                        if (sus_inc >= {1'b0, sustain_ticks}) state_nxt = S_RELEASE;
                    end
                    S_RELEASE: begin
                        env_nxt = env_rel;
                        if (env_rel == '0) state_nxt = S_IDLE;
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        env_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        adsr_state = state;
        env_level  = env;
    end

    logic              en;
    logic signed [XW:0] dx;
    logic signed [YW:0] dy;
    logic [CW-1:0]     adx, ady;
    logic [DW-1:0]     adx_w, ady_w, dist_sq;
    logic [RW2-1:0]    rad_w, r_sq;

    assign en           = !valid_out || output_ready;
    assign module_ready = en;

    assign dx      = $signed({1'b0, pixel_x}) - CX;
    assign dy      = $signed({1'b0, pixel_y}) - CY;
    assign adx     = CW'(dx[XW] ? -dx : dx);
    assign ady     = CW'(dy[YW] ? -dy : dy);
    assign adx_w   = DW'(adx);
    assign ady_w   = DW'(ady);
    assign dist_sq = adx_w * adx_w + ady_w * ady_w;
    assign rad_w   = RW2'(radius);
    assign r_sq    = rad_w * rad_w;

    logic [PW-1:0]   s1_pix;
    logic            s1_valid;
    logic [DW-1:0]   s1_dist;
    logic [RW2-1:0]  s1_rsq;
    logic [BITS-1:0] s1_env;
    logic [CMPW-1:0] d_cmp, r_cmp;
    logic [BITS-1:0] gain;
    logic [PW-1:0]   pix_calc;

    assign d_cmp = CMPW'(s1_dist);
    assign r_cmp = CMPW'(s1_rsq);

    always_comb begin
        gain = '0;
        if (filter_enable) begin
            if (d_cmp < (r_cmp >> 2))
                gain = s1_env;
            else if (d_cmp < r_cmp)
                gain = s1_env >> 1;
        end
    end

    always_comb begin
        logic [BITS-1:0] ch;
        logic [BITS:0]   sum;
        pix_calc = s1_pix;
        ch       = '0;
        sum      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch  = s1_pix[c*BITS +: BITS];
            sum = {1'b0, ch} + {1'b0, gain};
            if (gain != '0) begin
                if (filter_mode)
                    pix_calc[c*BITS +: BITS] = sum[BITS:1];
                else
                    pix_calc[c*BITS +: BITS] = sum[BITS] ? ENV_MAX : sum[BITS-1:0];
            end
        end
    end

    // both stages advance together so a stalled output holds the whole pipe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_pix    <= '0;
            s1_valid  <= 1'b0;
            s1_dist   <= '0;
            s1_rsq    <= '0;
            s1_env    <= '0;
            pix_out   <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            s1_pix    <= pix_in;
            s1_valid  <= valid_in;
            s1_dist   <= dist_sq;
            s1_rsq    <= r_sq;
            s1_env    <= env;
            pix_out   <= pix_calc;
            valid_out <= s1_valid;
        end
    end

endmodule

// File: tb/tb_adsr_pulse_overlay.sv
// Self-checking bench for adsr_pulse_overlay: envelope table, overlay vectors,
// backpressure stream, retrigger/enable/reset sequences.
`timescale 1ns/1ps
module tb_adsr_pulse_overlay;

    localparam int TD = 4;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] pix_in;
    logic          valid_in;
    logic          module_ready;
    logic [PW-1:0] pix_out;
    logic          valid_out;
    logic          output_ready;
    logic [9:0]    pixel_x;
    logic [8:0]    pixel_y;
    logic          filter_enable;
    logic          filter_mode;
    logic          trigger;
    logic [7:0]    attack_step, decay_step, release_step, sustain_level;
    logic [15:0]   sustain_ticks;
    logic [8:0]    radius;
    logic [7:0]    env_level;
    logic [2:0]    adsr_state;

    adsr_pulse_overlay #(
        .CHANNELS(3), .BITS(8), .IMAGE_WIDTH(640), .IMAGE_HEIGHT(480),
        .RADIUS_W(9), .TICK_DIV(TD), .SUS_W(16)
    ) dut (
        .clk(clk), .reset(rst),
        .pix_in(pix_in), .valid_in(valid_in), .module_ready(module_ready),
        .pix_out(pix_out), .valid_out(valid_out), .output_ready(output_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .filter_enable(filter_enable), .filter_mode(filter_mode),
        .trigger(trigger),
        .attack_step(attack_step), .decay_step(decay_step), .release_step(release_step),
        .sustain_level(sustain_level), .sustain_ticks(sustain_ticks),
        .radius(radius), .env_level(env_level), .adsr_state(adsr_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int out_cnt  = 0;
    int edge_cnt;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] mon_exp;

    typedef struct {
        logic [7:0] env;
        logic [2:0] st;
    } env_vec_t;

    typedef struct {
        logic [8:0]    rad;
        int            x;
        int            y;
        logic          mode;
        logic [PW-1:0] pix;
        logic [PW-1:0] expv;
    } pix_vec_t;

    env_vec_t      env_tab[12];
    pix_vec_t      pix_tab[11];
    logic [PW-1:0] stream[16];

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // scoreboard: every accepted output transfer is compared in order
    always @(negedge clk) begin
        #2;
        if (!rst && valid_out && output_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got 0x%0h expected none", pix_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pix_out", {8'h0, pix_out}, {8'h0, mon_exp});
                out_cnt++;
            end
        end
    end

    function automatic logic [PW-1:0] model(input logic [PW-1:0] p, input int x, input int y,
                                           input int r, input int e);
        int d2, r2, g, s;
        logic [PW-1:0] o;
        d2 = (x - 320) * (x - 320) + (y - 240) * (y - 240);
        r2 = r * r;
        if (d2 < (r2 >> 2))  g = e;
        else if (d2 < r2)    g = e / 2;
        else                 g = 0;
        o = p;
        for (int c = 0; c < 3; c++) begin
            s = int'(p[c*8 +: 8]) + g;
            if (s > 255) s = 255;
            if (g != 0) o[c*8 +: 8] = 8'(s);
        end
        return o;
    endfunction

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while ((edge_cnt % TD) != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic send_pix(input logic [PW-1:0] p, input int x, input int y, input logic [PW-1:0] e);
        @(negedge clk);
        pix_in   = p;
        pixel_x  = 10'(x);
        pixel_y  = 9'(y);
        valid_in = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc;
        logic stall_prev;
        logic [PW-1:0] held;

        env_tab[0]  = '{8'd64,  3'd1};
        env_tab[1]  = '{8'd128, 3'd1};
        env_tab[2]  = '{8'd192, 3'd1};
        env_tab[3]  = '{8'd255, 3'd2};
        env_tab[4]  = '{8'd223, 3'd2};
        env_tab[5]  = '{8'd191, 3'd2};
        env_tab[6]  = '{8'd159, 3'd2};
        env_tab[7]  = '{8'd128, 3'd3};
        env_tab[8]  = '{8'd128, 3'd3};
        env_tab[9]  = '{8'd128, 3'd4};
        env_tab[10] = '{8'd64,  3'd4};
        env_tab[11] = '{8'd0,   3'd0};

        pix_tab[0]  = '{9'd100, 320, 240, 1'b0, 24'h101010, 24'hFFFFFF};
        pix_tab[1]  = '{9'd100, 380, 240, 1'b0, 24'h101010, 24'h8F8F8F};
        pix_tab[2]  = '{9'd100, 420, 240, 1'b0, 24'h101010, 24'h101010};
        pix_tab[3]  = '{9'd100, 320, 240, 1'b1, 24'h101010, 24'h878787};
        pix_tab[4]  = '{9'd100, 380, 240, 1'b1, 24'h101010, 24'h474747};
        pix_tab[5]  = '{9'd100, 320, 290, 1'b0, 24'h101010, 24'h8F8F8F};
        pix_tab[6]  = '{9'd0,   320, 240, 1'b0, 24'h101010, 24'h101010};
        pix_tab[7]  = '{9'd100, 320, 240, 1'b1, 24'hF08000, 24'hF7BF7F};
        pix_tab[8]  = '{9'd100, 0,   0,   1'b0, 24'h123456, 24'h123456};
        pix_tab[9]  = '{9'd100, 320, 240, 1'b0, 24'hF08000, 24'hFFFFFF};
        pix_tab[10] = '{9'd100, 370, 210, 1'b0, 24'h010203, 24'h808182};

        for (int i = 0; i < 16; i++) stream[i] = 24'($urandom);

        rst = 1'b1;
        pix_in = '0; valid_in = 1'b0; output_ready = 1'b1;
        pixel_x = '0; pixel_y = '0;
        filter_enable = 1'b1; filter_mode = 1'b0; trigger = 1'b0;
        attack_step = 8'd64; decay_step = 8'd32; release_step = 8'd64;
        sustain_level = 8'd128; sustain_ticks = 16'd2; radius = 9'd100;
        #22;
        check("rst_valid_out", {31'h0, valid_out}, 32'h0);
        check("rst_pix_out", {8'h0, pix_out}, 32'h0);
        check("rst_env", {24'h0, env_level}, 32'h0);
        check("rst_state", {29'h0, adsr_state}, 32'h0);
        check("rst_ready", {31'h0, module_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // envelope sequence
        wait_tick();
        pulse();
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            check($sformatf("env_tick%0d", i), {24'h0, env_level}, {24'h0, env_tab[i].env});
            check($sformatf("state_tick%0d", i), {29'h0, adsr_state}, {29'h0, env_tab[i].st});
        end
        wait_tick();
        check("idle_hold_env", {24'h0, env_level}, 32'h0);
        check("idle_hold_state", {29'h0, adsr_state}, 32'h0);

        // retrigger in RELEASE at env 64
        pulse();
        for (int i = 0; i < 11; i++) wait_tick();
        check("pre_retrig_state", {29'h0, adsr_state}, 32'd4);
        check("pre_retrig_env", {24'h0, env_level}, 32'd64);
        pulse();
        wait_tick();
        check("retrig_state", {29'h0, adsr_state}, 32'd1);
        check("retrig_env", {24'h0, env_level}, 32'd128);

        // trigger edge coincident with a tick is consumed by that tick
        repeat (3) @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        check("coinc_state", {29'h0, adsr_state}, 32'd1);
        check("coinc_env", {24'h0, env_level}, 32'd192);
        trigger = 1'b0;
        wait_tick();
        check("coinc_consumed_state", {29'h0, adsr_state}, 32'd2);
        check("coinc_consumed_env", {24'h0, env_level}, 32'd255);

        // filter_enable dropped mid-ATTACK
        pulse();
        wait_tick();
        check("attack_before_disable", {29'h0, adsr_state}, 32'd1);
        filter_enable = 1'b0;
        @(negedge clk);
        check("disable_state", {29'h0, adsr_state}, 32'd0);
        check("disable_env", {24'h0, env_level}, 32'd0);
        pix_in = 24'hA5C3E1; pixel_x = 10'd320; pixel_y = 9'd240; valid_in = 1'b1;
        exp_q.push_back(24'hA5C3E1);
        @(negedge clk);
        valid_in = 1'b0;
        check("lat_cycle1_valid", {31'h0, valid_out}, 32'h0);
        @(negedge clk);
        check("lat_cycle2_valid", {31'h0, valid_out}, 32'h1);
        check("lat_cycle2_pix", {8'h0, pix_out}, 32'hA5C3E1);
        send_pix(24'h3C5A7E, 330, 245, 24'h3C5A7E);
        drain("passthru");
        filter_enable = 1'b1;

        // hold env at 255 in SUSTAIN for the overlay tests
        sustain_level = 8'd255;
        sustain_ticks = 16'hFFFF;
        wait_tick();
        pulse();
        repeat (6) wait_tick();
        check("hold_state", {29'h0, adsr_state}, 32'd3);
        check("hold_env", {24'h0, env_level}, 32'd255);

        for (int i = 0; i < 11; i++) begin
            radius      = pix_tab[i].rad;
            filter_mode = pix_tab[i].mode;
            send_pix(pix_tab[i].pix, pix_tab[i].x, pix_tab[i].y, pix_tab[i].expv);
            drain($sformatf("vec%0d", i));
        end

        // backpressure stream
        filter_mode = 1'b0;
        radius = 9'd100;
        out_cnt = 0;
        sent = 0;
        cyc = 0;
        stall_prev = 1'b0;
        held = '0;
        while ((sent < 16 || exp_q.size() != 0) && cyc < 100) begin
            @(negedge clk);
            output_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 16) begin
                pix_in   = stream[sent];
                pixel_x  = 10'(296 + sent * 8);
                pixel_y  = 9'(240 + (sent % 3) * 10);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (!output_ready && valid_out) begin
                check("stall_ready", {31'h0, module_ready}, 32'h0);
                if (stall_prev) check("stall_stable", {8'h0, pix_out}, {8'h0, held});
                held = pix_out;
            end
            stall_prev = !output_ready;
            if (valid_in && module_ready) begin
                exp_q.push_back(model(stream[sent], 296 + sent * 8, 240 + (sent % 3) * 10, 100, 255));
                sent++;
            end
            cyc++;
        end
        valid_in = 1'b0;
        output_ready = 1'b1;
        drain("backpressure");
        check("bp_out_count", 32'(out_cnt), 32'd16);

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_in   = 24'(i * 37 + 5);
            pixel_x  = 10'd320;
            pixel_y  = 9'd240;
            valid_in = 1'b1;
            exp_q.push_back(model(24'(i * 37 + 5), 320, 240, 100, 255));
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid_out", {31'h0, valid_out}, 32'h0);
        check("arst_pix_out", {8'h0, pix_out}, 32'h0);
        check("arst_env", {24'h0, env_level}, 32'h0);
        check("arst_state", {29'h0, adsr_state}, 32'h0);
        exp_q.delete();
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_tick();
        pulse();
        wait_tick();
        check("post_rst_state", {29'h0, adsr_state}, 32'd1);
        check("post_rst_env", {24'h0, env_level}, 32'd64);
        send_pix(24'h101010, 320, 240, 24'h505050);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
